// File: rtl/subbytes_enc_iter.sv
//------------------------------------------------------------------------------
// Module      : subbytes_enc_iter (with package subbytes_enc_iter_pkg and
//               leaf modules sbox / sboxi)
// Description : Iterative forward AES SubBytes on a 128-bit state.
//               BYTES_PER_CYCLE bytes are substituted per clock through
//               parallel sbox lanes, so one block takes 16/BYTES_PER_CYCLE
//               clocks. Valid/ready handshake on input and output; a new
//               block is only accepted once the previous result has been
//               taken (no overlap).
//
//               Optional feature macro: SUBBYTES_INV_EN
//                 defined   -> extra input 'inv', sampled with in_data at
//                              acceptance; inv=1 selects the inverse S-box
//                              (sboxi lanes) for that block.
//                 undefined -> forward substitution only, no sboxi lanes.
//
// Ports       : clk        in   1    rising-edge clock
//               rst_n      in   1    asynchronous active-low reset
//               in_valid   in   1    in_data is valid
//               in_ready   out  1    block can accept in_data (state IDLE)
//               in_data    in   128  byte0 = [127:120] ... byte15 = [7:0]
//               inv        in   1    (SUBBYTES_INV_EN only) inverse select
//               out_valid  out  1    out_data holds a completed result
//               out_ready  in   1    downstream accepts out_data
//               out_data   out  128  substituted state, same byte order
//               busy       out  1    block is in BUSY or DONE
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package subbytes_enc_iter_pkg;

  // GF(2^8) multiply, AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (square-and-multiply over the exponent
  // bits 1111_1110). Maps 0 to 0, which is what the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, sq);
      sq = gf_mul(sq, sq);
    end
    return r;
  endfunction

  // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return {s[6:0], s[7]}
         ^ {s[4:0], s[7:5]}
         ^ {s[1:0], s[7:2]}
         ^ 8'h05;
  endfunction

endpackage

//------------------------------------------------------------------------------
// Forward AES S-box lane.
//------------------------------------------------------------------------------
module sbox (
  input  logic [7:0] a,
  output logic [7:0] c
);
  import subbytes_enc_iter_pkg::*;

  assign c = affine_fwd(gf_inv(a));
endmodule

`ifdef SUBBYTES_INV_EN
//------------------------------------------------------------------------------
// Inverse AES S-box lane.
//------------------------------------------------------------------------------
module sboxi (
  input  logic [7:0] a,
  output logic [7:0] c
);
  import subbytes_enc_iter_pkg::*;

  assign c = gf_inv(affine_inv(a));
endmodule
`endif

//------------------------------------------------------------------------------
// Top: iterative SubBytes engine.
//------------------------------------------------------------------------------
module subbytes_enc_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef SUBBYTES_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CHUNK_W   = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  generate
    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $error("subbytes_enc_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_step;
  logic [127:0]         r_work;
  logic [127:0]         w_work_nxt;
  logic [CHUNK_W-1:0]   w_chunk_in;
  logic [CHUNK_W-1:0]   w_chunk_out;
  logic [CHUNK_W-1:0]   w_chunk_fwd;
  logic                 w_accept;
  logic                 w_release;
  logic                 w_last_step;
`ifdef SUBBYTES_INV_EN
  logic                 r_inv;
  logic [CHUNK_W-1:0]   w_chunk_inv;
`endif

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign busy        = (r_state == ST_BUSY) || (r_state == ST_DONE);
  assign out_data    = r_work;

  assign w_accept    = in_valid && in_ready;
  assign w_release   = out_valid && out_ready;
  assign w_last_step = (r_step == CNT_W'(NUM_STEPS - 1));

  //--------------------------------------------------------------------------
  // FSM state register and next-state logic
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_state_nxt = ST_BUSY;
      ST_BUSY: if (w_last_step) w_state_nxt = ST_DONE;
      ST_DONE: if (w_release)   w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Chunk select / write-back. Step k owns bytes k*BPC .. k*BPC+BPC-1, which
  // sit MSB-first at bit offset 127 - k*CHUNK_W of the work register.
  //--------------------------------------------------------------------------
  always_comb begin
    w_chunk_in = '0;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (r_step == CNT_W'(k)) begin
        w_chunk_in = r_work[127 - k*CHUNK_W -: CHUNK_W];
      end
    end
  end

  always_comb begin
    w_work_nxt = r_work;
    for (int k = 0; k < NUM_STEPS; k++) begin
      if (r_step == CNT_W'(k)) begin
        w_work_nxt[127 - k*CHUNK_W -: CHUNK_W] = w_chunk_out;
      end
    end
  end

  //--------------------------------------------------------------------------
  // Substitution lanes, one per byte of the chunk (lane 0 = MSB byte).
  //--------------------------------------------------------------------------
  generate
    for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_lane
      sbox u_sbox (
        .a (w_chunk_in [CHUNK_W - 1 - 8*j -: 8]),
        .c (w_chunk_fwd[CHUNK_W - 1 - 8*j -: 8])
      );
`ifdef SUBBYTES_INV_EN
      sboxi u_sboxi (
        .a (w_chunk_in [CHUNK_W - 1 - 8*j -: 8]),
        .c (w_chunk_inv[CHUNK_W - 1 - 8*j -: 8])
      );
`endif
    end
  endgenerate

`ifdef SUBBYTES_INV_EN
  // Direction is latched at acceptance so a later change on 'inv' cannot
  // mix forward and inverse bytes within one block.
  assign w_chunk_out = r_inv ? w_chunk_inv : w_chunk_fwd;
`else
  assign w_chunk_out = w_chunk_fwd;
`endif

  //--------------------------------------------------------------------------
  // Datapath: work register, step counter, direction flag
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work <= '0;
      r_step <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_work <= in_data;
            r_step <= '0;
          end
        end
        ST_BUSY: begin
          r_work <= w_work_nxt;
          // Wraps to zero on the edge that enters DONE.
          r_step <= w_last_step ? '0 : r_step + CNT_W'(1);
        end
        default: begin
          // DONE holds the result stable under backpressure.
        end
      endcase
    end
  end

`ifdef SUBBYTES_INV_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inv <= 1'b0;
    end else if (w_accept) begin
      r_inv <= inv;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_subbytes_enc_iter.sv
//------------------------------------------------------------------------------
// Module      : tb_subbytes_enc_iter
// Description : Self-checking bench for subbytes_enc_iter (default
//               BYTES_PER_CYCLE). Expected blocks come from a table-driven
//               S-box model built by brute-force field inversion and are
//               queued on acceptance, popped when out_valid appears.
//               With SUBBYTES_INV_EN defined the inverse path is exercised.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_subbytes_enc_iter;

  localparam int BPC     = 4;
  localparam int STEPS   = 16 / BPC;
  localparam int TIMEOUT = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] sb[$];
  logic [7:0]   fwd_tab[256];
  logic [7:0]   inv_tab[256];

  always #5 clk = ~clk;

  subbytes_enc_iter #(.BYTES_PER_CYCLE(BPC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SUBBYTES_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  //--------------------------------------------------------------------------
  // Reference model
  //--------------------------------------------------------------------------
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    logic [7:0] c = 8'h63;
    logic [7:0] r;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && m_mul(x, 8'(y)) == 8'h01) b = 8'(y);
    end
    for (int i = 0; i < 8; i++) begin
      r[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    end
    return r;
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      fwd_tab[x] = m_sbox(8'(x));
    end
    for (int x = 0; x < 256; x++) begin
      inv_tab[fwd_tab[x]] = 8'(x);
    end
  endtask

  function automatic logic [127:0] m_block(input logic [127:0] d, input logic use_inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) begin
      r[127 - 8*i -: 8] = use_inv ? inv_tab[d[127 - 8*i -: 8]] : fwd_tab[d[127 - 8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  //--------------------------------------------------------------------------
  // One complete block with out_ready=1; checks latency, data, 1-cycle pulse.
  //--------------------------------------------------------------------------
  task automatic run_block(input logic [127:0] data, input logic use_inv,
                           input string name, output logic [127:0] got);
    logic [127:0] exp;
    int lat;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready_before: got=%b want=1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_data   = data;
    inv       = use_inv;
    out_ready = 1'b1;
    sb.push_back(m_block(data, use_inv));
    tick();
    in_valid = 1'b0;
    in_data  = rand128();
    inv      = ~use_inv;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    total++;
    if (lat != STEPS) begin
      bad++;
      $display("FAIL %s latency: got=%0d want=%0d", name, lat, STEPS);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 128'h0;
    got = out_data;
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL %s data: got=%h want=%h", name, out_data, exp);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s pulse_end: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  //--------------------------------------------------------------------------
  // Tests
  //--------------------------------------------------------------------------
  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    inv       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: out_valid=%b busy=%b want 0/0", out_valid, busy);
    end
    total++;
    if (out_data !== 128'h0) begin
      bad++;
      $display("FAIL reset_data: got=%h want=0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_known_vectors();
    logic [127:0] got;
    run_block(128'h0, 1'b0, "zero", got);
    total++;
    if (got !== 128'h63636363_63636363_63636363_63636363) begin
      bad++;
      $display("FAIL zero_const: got=%h want=63..63", got);
    end
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, "fips", got);
    total++;
    if (got !== 128'h638293c3_1bfc33f5_c4eeacea_4bc12816) begin
      bad++;
      $display("FAIL fips_const: got=%h want=638293c31bfc33f5c4eeacea4bc12816", got);
    end
  endtask

  task automatic test_random();
    logic [127:0] got;
    for (int n = 0; n < 6; n++) begin
      run_block(rand128(), 1'b0, $sformatf("rand%0d", n), got);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp;
    int lat;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_in_ready_before: got=%b want=1", in_ready);
    end
    in_data   = rand128();
    in_valid  = 1'b1;
    inv       = 1'b0;
    out_ready = 1'b0;
    sb.push_back(m_block(in_data, 1'b0));
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    total++;
    if (lat != STEPS) begin
      bad++;
      $display("FAIL bp_latency: got=%0d want=%0d", lat, STEPS);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 128'h0;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold_flags[%0d]: out_valid=%b in_ready=%b busy=%b want 1/0/1",
                 i, out_valid, in_ready, busy);
      end
      total++;
      if (out_data !== exp) begin
        bad++;
        $display("FAIL bp_hold_data[%0d]: got=%h want=%h", i, out_data, exp);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1/0/0",
               in_ready, out_valid, busy);
    end
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL bp_idle_keep: got=%h want=%h", out_data, exp);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] a;
    logic [127:0] exp;
    int lat;
    int busy_ready_hits;
    a = rand128();
    in_data   = a;
    in_valid  = 1'b1;
    inv       = 1'b0;
    out_ready = 1'b1;
    sb.push_back(m_block(a, 1'b0));
    tick();
    in_data = ~a ^ rand128();
    lat = 0;
    busy_ready_hits = 0;
    while (out_valid !== 1'b1 && lat < TIMEOUT) begin
      if (in_ready !== 1'b0) busy_ready_hits++;
      tick();
      lat++;
      in_data = rand128();
    end
    in_valid = 1'b0;
    total++;
    if (busy_ready_hits != 0 || lat != STEPS) begin
      bad++;
      $display("FAIL ignore_busy: in_ready_high_cycles=%0d lat=%0d want 0/%0d",
               busy_ready_hits, lat, STEPS);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 128'h0;
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("FAIL ignore_data: got=%h want=%h", out_data, exp);
    end
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_second: busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_abort();
    logic [127:0] got;
    int pulses;
    in_data   = rand128();
    in_valid  = 1'b1;
    inv       = 1'b0;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 128'h0) begin
      bad++;
      $display("FAIL abort_now: out_valid=%b busy=%b data=%h want 0/0/0",
               out_valid, busy, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < STEPS + 3; i++) begin
      tick();
      if (out_valid !== 1'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_pulse: out_valid_cycles=%0d want 0", pulses);
    end
    run_block(rand128(), 1'b0, "after_abort", got);
  endtask

`ifdef SUBBYTES_INV_EN
  task automatic test_inverse();
    logic [127:0] got;
    run_block({16{8'h63}}, 1'b1, "inv63", got);
    total++;
    if (got !== 128'h0) begin
      bad++;
      $display("FAIL inv63_const: got=%h want=0", got);
    end
    run_block({16{8'h53}}, 1'b0, "fwd53", got);
    total++;
    if (got !== {16{8'hed}}) begin
      bad++;
      $display("FAIL fwd53_const: got=%h want=ed..ed", got);
    end
    run_block(rand128(), 1'b1, "inv_rand", got);
  endtask
`endif

  initial begin
    build_tables();
    test_reset();
    test_known_vectors();
    test_random();
    test_backpressure();
    test_busy_ignore();
    test_abort();
`ifdef SUBBYTES_INV_EN
    test_inverse();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
